ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's 8x4 dual-port RAM (write_en/write_addr/write_data in, read_en/read_addr in, registered read_data out with 1-cycle latency).
- Turns push/pop requests into RAM port accesses, manages circular pointers, and reports occupancy and full/empty/almost flags.
- Returns read data with a valid strobe, and records overflow/underflow errors in sticky flags.

Parameters:
- AW, 3, RAM index width; depth = 2**AW = 8.
- DW, 4, data width.
- AF_TH, 6, almost_full asserted when count >= AF_TH.
- AE_TH, 1, almost_empty asserted when count <= AE_TH.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous, active-low reset.
- push  in  1  Write request.
- push_data  in  DW  Data to write.
- pop  in  1  Read request.
- err_clr  in  1  Clears the sticky error flags.
- ram_write_en  out  1  To RAM write_en.
- ram_write_addr  out  8  To RAM write_addr; index zero-extended to 8 bits.
- ram_write_data  out  DW  To RAM write_data.
- ram_read_en  out  1  To RAM read_en.
- ram_read_addr  out  8  To RAM read_addr; index zero-extended to 8 bits.
- ram_read_data  in  DW  From RAM read_data.
- pop_data  out  DW  Returned data, equal to ram_read_data.
- pop_valid  out  1  pop_data is valid this cycle.
- count  out  AW+1  Current occupancy, 0..8.
- full  out  1  count == 8.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- overflow  out  1  Sticky: a push was rejected.
- underflow  out  1  Sticky: a pop was rejected.

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: wptr = 0, rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, pop_valid = 0, overflow = 0, underflow = 0. RAM contents are reset by the RAM itself.
- Pointers: wptr and rptr are AW+1 bits wide and wrap modulo 16. The low AW bits are the RAM index, so 7 -> 0 wraps naturally.
- Flags:
  - full when the pointer MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - count = wptr - rptr, mod 16.
  - All flags derive only from registers, with no combinational path from push or pop.
- Acceptance:
  - push_acc = push & !full.
  - pop_acc = pop & !empty.
  - Both are evaluated against the flags registered at the start of the cycle.
- RAM drive (combinational from push/pop and registers):
  - ram_write_en = push_acc; ram_write_addr = wptr index; ram_write_data = push_data.
  - ram_read_en = pop_acc; ram_read_addr = rptr index.
- Pointer update on the clock edge:
  - wptr increments on push_acc.
  - rptr increments on pop_acc.
  - count changes by +1, -1, or 0 (both accepted).
- Read latency:
  - pop_valid is a register loaded with pop_acc, so it pulses in the cycle after an accepted pop.
  - pop_data = ram_read_data, meaningful only while pop_valid = 1.
  - Back-to-back pops give one valid word per cycle.
- Simultaneous push + pop:
  - When not full and not empty: both accepted; count unchanged.
  - When full: pop accepted, push rejected (sets overflow). There is no write-through into the slot being freed.
  - When empty: push accepted, pop rejected (sets underflow). There is no bypass; the data becomes readable the next cycle.
- Errors:
  - overflow is set on push & full; underflow is set on pop & empty.
  - Both hold until err_clr. If a set event and err_clr occur in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately. An in-flight pop_valid is dropped.

Test Plan:
- Reset, then 8 pushes of data 1..8 -> count steps 1..8. almost_full rises when count reaches 6; full rises after the 8th push. ram_write_addr runs 0..7. No overflow.
- From full, 8 consecutive pops -> ram_read_addr runs 0..7. pop_valid is high for 8 cycles, starting one cycle after the first pop. pop_data runs 1..8. empty = 1 at the end.
- Push when full (data 9) -> ram_write_en = 0, overflow = 1, count stays 8. Assert err_clr -> overflow = 0.
- Pop when empty -> ram_read_en = 0, pop_valid stays 0, underflow = 1. Push + pop together when empty -> count = 1, underflow = 1.
- Wrap-around: push 5 / pop 5 three times, then push A, B, C -> write indices wrap 7 -> 0 with correct data returned. Push + pop together at count 3 -> count stays 3.
- Assert rst_n low mid-stream, with count = 4 and pop_valid = 1 -> all outputs go to reset values immediately. After release, empty = 1 and a subsequent push/pop round-trips correctly.

Source files
------------

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the FIFO user-side handshake and the RAM port wiring.
// master: the surrounding logic (producer/consumer and the RAM itself).
// slave:  the FIFO controller.
interface ram_fifo_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 4
);
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic          err_clr;
  logic          ram_write_en;
  logic [7:0]    ram_write_addr;
  logic [DW-1:0] ram_write_data;
  logic          ram_read_en;
  logic [7:0]    ram_read_addr;
  logic [DW-1:0] ram_read_data;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, push_data, pop, err_clr, ram_read_data,
    input  ram_write_en, ram_write_addr, ram_write_data,
    input  ram_read_en, ram_read_addr, pop_data, pop_valid,
    input  count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, err_clr, ram_read_data,
    output ram_write_en, ram_write_addr, ram_write_data,
    output ram_read_en, ram_read_addr, pop_data, pop_valid,
    output count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an 8x4 dual-port RAM with 1-cycle registered read.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter; all status flags come from pointer registers only.
module ram_fifo_ctrl #(
  parameter int AW    = 3,
  parameter int DW    = 4,
  parameter int AF_TH = 6,
  parameter int AE_TH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_fifo_ctrl_if.slave  bus
);
  localparam logic [AW:0] AF_LIM = (AW+1)'(AF_TH);
  localparam logic [AW:0] AE_LIM = (AW+1)'(AE_TH);

  logic [AW:0] wptr_reg;
  logic [AW:0] rptr_reg;
  logic        pop_valid_reg;
  logic        overflow_reg;
  logic        underflow_reg;

  logic [AW:0] count_w;
  logic        full_w;
  logic        empty_w;
  logic        push_acc;
  logic        pop_acc;

  // Occupancy and flags, purely from the pointer registers.
  assign count_w  = wptr_reg - rptr_reg;
  assign empty_w  = (wptr_reg == rptr_reg);
  assign full_w   = (wptr_reg[AW] != rptr_reg[AW]) &&
                    (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

  // A request is taken only if the flags at the start of the cycle allow it;
  // there is no write-through when full and no bypass when empty.
  assign push_acc = bus.push & ~full_w;
  assign pop_acc  = bus.pop & ~empty_w;

  assign bus.ram_write_en   = push_acc;
  assign bus.ram_write_addr = 8'(wptr_reg[AW-1:0]);
  assign bus.ram_write_data = bus.push_data;
  assign bus.ram_read_en    = pop_acc;
  assign bus.ram_read_addr  = 8'(rptr_reg[AW-1:0]);

  assign bus.pop_data     = bus.ram_read_data;
  assign bus.pop_valid    = pop_valid_reg;
  assign bus.count        = count_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_w >= AF_LIM);
  assign bus.almost_empty = (count_w <= AE_LIM);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

  // Advance the circular pointers on accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (push_acc) wptr_reg <= wptr_reg + 1'b1;
      if (pop_acc)  rptr_reg <= rptr_reg + 1'b1;
    end
  end

  // Valid strobe lines up with the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_valid_reg <= 1'b0;
    else        pop_valid_reg <= pop_acc;
  end

  // Sticky error flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.push && full_w)      overflow_reg <= 1'b1;
      else if (bus.err_clr)        overflow_reg <= 1'b0;
      if (bus.pop && empty_w)      underflow_reg <= 1'b1;
      else if (bus.err_clr)        underflow_reg <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: a queue-based FIFO model plus a
// behavioural 8x4 RAM with registered read.
module tb_ram_fifo_ctrl;
  logic clk;
  logic rst_n;

  ram_fifo_ctrl_if #(.AW(3), .DW(4)) bus ();

  ram_fifo_ctrl #(.AW(3), .DW(4), .AF_TH(6), .AE_TH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, registered read.
  logic [3:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_write_addr[2:0]] <= bus.ram_write_data;
    if (bus.ram_read_en)  bus.ram_read_data <= mem[bus.ram_read_addr[2:0]];
  end

  int total;
  int bad;

  // Reference model state.
  logic [3:0] q[$];
  int         wcnt, rcnt;
  bit         ovf_m, unf_m, pv_m;
  logic [3:0] pd_m;

  // Pre-edge snapshot of the combinational RAM drive and its expectation.
  logic       obs_wen, obs_ren, exp_wen, exp_ren;
  logic [7:0] obs_waddr, obs_raddr, exp_waddr, exp_raddr;
  logic [3:0] obs_wdata, exp_wdata;

  task automatic model_reset();
    q.delete();
    wcnt = 0; rcnt = 0;
    ovf_m = 0; unf_m = 0; pv_m = 0; pd_m = '0;
  endtask

  // One clock cycle: drive inputs, snapshot RAM drive, clock, update model.
  task automatic tick(input bit p, input logic [3:0] d, input bit po, input bit ec);
    bit pa, pp;
    int n;
    bus.push = p; bus.push_data = d; bus.pop = po; bus.err_clr = ec;
    #1;
    obs_wen = bus.ram_write_en; obs_waddr = bus.ram_write_addr; obs_wdata = bus.ram_write_data;
    obs_ren = bus.ram_read_en;  obs_raddr = bus.ram_read_addr;
    n  = q.size();
    pa = p && (n < 8);
    pp = po && (n > 0);
    exp_wen = pa; exp_waddr = 8'(wcnt % 8); exp_wdata = d;
    exp_ren = pp; exp_raddr = 8'(rcnt % 8);
    @(posedge clk);
    pv_m = pp;
    if (pp) begin pd_m = q.pop_front(); rcnt++; end
    if (pa) begin q.push_back(d); wcnt++; end
    if (p && n == 8) ovf_m = 1; else if (ec) ovf_m = 0;
    if (po && n == 0) unf_m = 1; else if (ec) unf_m = 0;
    if (pa || pp)
      $display("t=%0t push=%0b/%0h pop=%0b occ=%0d", $time, pa, d, pp, q.size());
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.push = 0; bus.push_data = '0; bus.pop = 0; bus.err_clr = 0;
    model_reset();
    #12;
    total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", bus.full); end
    total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b exp=1", bus.almost_empty); end
    total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b exp=0", bus.almost_full); end
    total++; if (bus.pop_valid !== 1'b0) begin bad++; $display("FAIL rst_pv got=%b exp=0", bus.pop_valid); end
    total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b%b exp=00", bus.overflow, bus.underflow); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 4'(i), 1'b0, 1'b0);
      total++; if (obs_wen !== 1'b1) begin bad++; $display("FAIL fill_wen i=%0d got=%b exp=1", i, obs_wen); end
      total++; if (obs_waddr !== 8'(i-1)) begin bad++; $display("FAIL fill_waddr i=%0d got=%0d exp=%0d", i, obs_waddr, i-1); end
      total++; if (obs_wdata !== 4'(i)) begin bad++; $display("FAIL fill_wdata got=%0h exp=%0h", obs_wdata, i); end
      total++; if (bus.count !== 4'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i); end
      total++; if (bus.almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_af i=%0d got=%b", i, bus.almost_full); end
      total++; if (bus.full !== (i == 8)) begin bad++; $display("FAIL fill_full i=%0d got=%b", i, bus.full); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b exp=0", bus.overflow); end
    end
  endtask

  task automatic test_overflow();
    tick(1'b1, 4'h9, 1'b0, 1'b0);
    total++; if (obs_wen !== 1'b0) begin bad++; $display("FAIL ovf_wen got=%b exp=0", obs_wen); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
    total++; if (bus.count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", bus.count); end
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
    tick(1'b1, 4'h9, 1'b0, 1'b1);
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_setwins got=%b exp=1", bus.overflow); end
    tick(1'b0, 4'h0, 1'b0, 1'b1);
    total++; if (bus.overflow !== ovf_m) begin bad++; $display("FAIL ovf_clr2 got=%b exp=%b", bus.overflow, ovf_m); end
    total++; if (bus.pop_valid !== 1'b0) begin bad++; $display("FAIL ovf_pv got=%b exp=0", bus.pop_valid); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 4'h0, 1'b1, 1'b0);
      total++; if (obs_ren !== 1'b1) begin bad++; $display("FAIL drain_ren k=%0d got=%b exp=1", k, obs_ren); end
      total++; if (obs_raddr !== 8'(k)) begin bad++; $display("FAIL drain_raddr got=%0d exp=%0d", obs_raddr, k); end
      total++; if (bus.pop_valid !== 1'b1) begin bad++; $display("FAIL drain_pv k=%0d got=%b exp=1", k, bus.pop_valid); end
      total++; if (bus.pop_data !== 4'(k+1)) begin bad++; $display("FAIL drain_data got=%0h exp=%0h", bus.pop_data, k+1); end
    end
    tick(1'b0, 4'h0, 1'b0, 1'b0);
    total++; if (bus.pop_valid !== 1'b0) begin bad++; $display("FAIL drain_pv_end got=%b exp=0", bus.pop_valid); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_underflow();
    tick(1'b0, 4'h0, 1'b1, 1'b0);
    total++; if (obs_ren !== 1'b0) begin bad++; $display("FAIL unf_ren got=%b exp=0", obs_ren); end
    total++; if (bus.pop_valid !== 1'b0) begin bad++; $display("FAIL unf_pv got=%b exp=0", bus.pop_valid); end
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", bus.underflow); end
    tick(1'b1, 4'h5, 1'b1, 1'b0);
    total++; if (obs_ren !== 1'b0 || obs_wen !== 1'b1) begin bad++; $display("FAIL unf_both_en got=%b%b exp=01", obs_ren, obs_wen); end
    total++; if (bus.count !== 4'd1) begin bad++; $display("FAIL unf_both_count got=%0d exp=1", bus.count); end
    total++; if (bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0) begin bad++; $display("FAIL unf_both got=%b%b exp=10", bus.underflow, bus.pop_valid); end
    tick(1'b0, 4'h0, 1'b1, 1'b1);
    total++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'h5) begin bad++; $display("FAIL unf_next got=%b/%0h exp=1/5", bus.pop_valid, bus.pop_data); end
    total++; if (bus.underflow !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("FAIL unf_clr got=%b%b exp=01", bus.underflow, bus.empty); end
  endtask

  task automatic test_wrap();
    logic [3:0] d;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        d = 4'($urandom);
        tick(1'b1, d, 1'b0, 1'b0);
        total++; if (obs_waddr !== exp_waddr) begin bad++; $display("FAIL wrap_waddr got=%0d exp=%0d", obs_waddr, exp_waddr); end
      end
      for (int i = 0; i < 5; i++) begin
        tick(1'b0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_raddr !== exp_raddr) begin bad++; $display("FAIL wrap_raddr got=%0d exp=%0d", obs_raddr, exp_raddr); end
        total++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== pd_m) begin bad++; $display("FAIL wrap_data got=%b/%0h exp=1/%0h", bus.pop_valid, bus.pop_data, pd_m); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      d = 4'(10 + i);
      tick(1'b1, d, 1'b0, 1'b0);
      total++; if (obs_waddr !== exp_waddr) begin bad++; $display("FAIL wrap_abc_waddr got=%0d exp=%0d", obs_waddr, exp_waddr); end
    end
    tick(1'b1, 4'hD, 1'b1, 1'b0);
    total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL wrap_both_count got=%0d exp=3", bus.count); end
    total++; if (bus.pop_data !== 4'hA || bus.pop_valid !== 1'b1) begin bad++; $display("FAIL wrap_both_data got=%b/%0h exp=1/a", bus.pop_valid, bus.pop_data); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 4'h0, 1'b1, 1'b0);
      total++; if (bus.pop_data !== pd_m) begin bad++; $display("FAIL wrap_tail got=%0h exp=%0h", bus.pop_data, pd_m); end
    end
    tick(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 4'(3 + i), 1'b0, 1'b0);
    tick(1'b0, 4'h0, 1'b1, 1'b0);
    total++; if (bus.count !== 4'd4 || bus.pop_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre got=%0d/%b exp=4/1", bus.count, bus.pop_valid); end
    bus.pop = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL mrst_flags got=%0d/%b/%b exp=0/1/0", bus.count, bus.empty, bus.full); end
    total++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin bad++; $display("FAIL mrst_almost got=%b%b exp=10", bus.almost_empty, bus.almost_full); end
    total++; if (bus.pop_valid !== 1'b0) begin bad++; $display("FAIL mrst_pv got=%b exp=0", bus.pop_valid); end
    total++; if ({bus.overflow, bus.underflow} !== 2'b00) begin bad++; $display("FAIL mrst_err got=%b%b exp=00", bus.overflow, bus.underflow); end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mrst_post_empty got=%b exp=1", bus.empty); end
    tick(1'b1, 4'h7, 1'b0, 1'b0);
    total++; if (obs_waddr !== 8'd0) begin bad++; $display("FAIL mrst_waddr got=%0d exp=0", obs_waddr); end
    tick(1'b0, 4'h0, 1'b1, 1'b0);
    total++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'h7) begin bad++; $display("FAIL mrst_rt got=%b/%0h exp=1/7", bus.pop_valid, bus.pop_data); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL mrst_rt_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_random();
    bit p, po, ec;
    int sz;
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 30));
      po = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 75));
      ec = ($urandom_range(0, 99) < 6);
      tick(p, 4'($urandom), po, ec);
      sz = q.size();
      total++; if (obs_wen !== exp_wen || obs_ren !== exp_ren) begin bad++; $display("FAIL rnd_en i=%0d got=%b%b exp=%b%b", i, obs_wen, obs_ren, exp_wen, exp_ren); end
      total++; if ((exp_wen && (obs_waddr !== exp_waddr || obs_wdata !== exp_wdata)) || (exp_ren && obs_raddr !== exp_raddr)) begin bad++; $display("FAIL rnd_addr i=%0d got=%0d/%0d exp=%0d/%0d", i, obs_waddr, obs_raddr, exp_waddr, exp_raddr); end
      total++; if (bus.count !== 4'(sz)) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, bus.count, sz); end
      total++; if ({bus.full, bus.empty, bus.almost_full, bus.almost_empty} !== {sz == 8, sz == 0, sz >= 6, sz <= 1}) begin bad++; $display("FAIL rnd_flags i=%0d got=%b%b%b%b sz=%0d", i, bus.full, bus.empty, bus.almost_full, bus.almost_empty, sz); end
      total++; if (bus.overflow !== ovf_m || bus.underflow !== unf_m) begin bad++; $display("FAIL rnd_err i=%0d got=%b%b exp=%b%b", i, bus.overflow, bus.underflow, ovf_m, unf_m); end
      total++; if (bus.pop_valid !== pv_m || (pv_m && bus.pop_data !== pd_m)) begin bad++; $display("FAIL rnd_pop i=%0d got=%b/%0h exp=%b/%0h", i, bus.pop_valid, bus.pop_data, pv_m, pd_m); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
